// File: rtl/imem_responder.sv
// imem_responder: pipelined instruction-memory responder with a host load port.
// A fetch accepted in SERVE is answered LATENCY cycles later from a synchronous-read array.
// ld_start walks SERVE -> DRAIN (let in-flight fetches finish) -> LOAD (host writes words from
// index 0) -> SERVE.
// Build option: define IMEM_ALIGN_CHECK_EN to make misaligned fetches return NOP_WORD and pulse
// the extra align_err output together with that response.

module imem_responder #(
  parameter int unsigned AW       = 10,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [31:0]   exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  output logic [AW:0]   ld_count,
  output logic          busy
`ifdef IMEM_ALIGN_CHECK_EN
  ,
  output logic          align_err
`endif
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..4");
  end

  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("imem_responder: AW must be in 1..29");
  end

  typedef enum logic [1:0] {StServe, StDrain, StLoad} state_e;

  state_e             state;
  logic [AW-1:0]      ptr;
  logic [LATENCY-1:0] vld_q;
  logic               nop_q;
  logic [31:0]        rd_q;
  logic [31:0]        mem [2**AW];

  logic               accept;
  logic               wr_en;
  logic [AW-1:0]      idx;
  logic               out_of_range;
  logic               fetch_nop;
  logic [31:0]        first_word;
  logic [31:0]        last_word;

  assign accept       = (state == StServe) && exIns_ren;
  assign wr_en        = (state == StLoad) && ld_valid;
  assign idx          = exIns_addr[AW+1:2];
  assign out_of_range = |exIns_addr[31:AW+2];

`ifdef IMEM_ALIGN_CHECK_EN
  logic               misalign;
  logic [LATENCY-1:0] aerr_q;

  assign misalign  = |exIns_addr[1:0];
  assign fetch_nop = out_of_range | misalign;

  // Alignment-error flag travels alongside the valid bit of its response.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aerr_q <= '0;
    end else begin
      aerr_q[0] <= accept & misalign;
      for (int i = 1; i < LATENCY; i++) aerr_q[i] <= aerr_q[i-1];
    end
  end

  assign align_err = aerr_q[LATENCY-1];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^exIns_addr[1:0];
  assign fetch_nop       = out_of_range;
`endif

  // Host write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= ld_data;
  end

  // Synchronous read port. Reads and writes never share an edge: reads only in SERVE,
  // writes only in LOAD.
  always_ff @(posedge clk) begin
    if (accept) rd_q <= mem[idx];
  end

  // Response valid pipeline plus the NOP substitution flag for the read stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q <= '0;
      nop_q <= 1'b0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
      if (accept) nop_q <= fetch_nop;
    end
  end

  assign first_word = nop_q ? NOP_WORD : rd_q;

  if (LATENCY == 1) begin : g_direct
    assign last_word = first_word;
  end else begin : g_stages
    logic [31:0] stage_q [LATENCY-1];

    // Extra output stages that stretch the read to LATENCY cycles.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int i = 0; i < LATENCY - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= first_word;
        for (int i = 1; i < LATENCY - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign last_word = stage_q[LATENCY-2];
  end

  assign exIns_valid = vld_q[LATENCY-1];
  // Zero when idle so the bus never shows stale or uninitialised array data.
  assign exIns_in    = exIns_valid ? last_word : '0;

  // Serve/drain/load controller with registered handshake and status outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= StServe;
      ptr      <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_count <= '0;
      busy     <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      unique case (state)
        StServe: begin
          if (ld_start) begin
            state <= StDrain;
            busy  <= 1'b1;
          end
        end
        StDrain: begin
          // Wait until every accepted fetch has produced its response.
          if (vld_q == '0) begin
            state    <= StLoad;
            ld_ready <= 1'b1;
            ptr      <= '0;
          end
        end
        StLoad: begin
          if (ld_valid) begin
            ptr <= ptr + AW'(1);
            // Finish on an explicit last beat or once the top index has been written.
            if (ld_last || (ptr == '1)) begin
              state    <= StServe;
              ld_ready <= 1'b0;
              busy     <= 1'b0;
              ld_done  <= 1'b1;
              ld_count <= {1'b0, ptr} + (AW+1)'(1);
            end
          end
        end
        default: begin
          state    <= StServe;
          ld_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: random and directed stimulus, checked every cycle against a
// queue-based reference model, plus literal expectations for the named scenarios.

module tb_imem_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 3;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] addr = '0;
  logic        exIns_valid;
  logic [31:0] exIns_in;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_done;
  logic [AW:0] ld_count;
  logic        busy;
`ifdef IMEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  always #5 clk = ~clk;

  imem_responder #(.AW(AW), .LATENCY(LAT), .NOP_WORD(NOP)) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .exIns_ren  (ren),
    .exIns_addr (addr),
    .exIns_valid(exIns_valid),
    .exIns_in   (exIns_in),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_count   (ld_count),
    .busy       (busy)
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    .align_err  (align_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] word;
    bit          aerr;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mmem [DEPTH];
  int          m_phase = 0;  // 0 serving, 1 draining, 2 loading
  int          m_ptr   = 0;
  int          m_count = 0;
  bit          m_done  = 1'b0;
  int          cyc     = 0;

  function automatic resp_t ref_fetch(input logic [31:0] a, input int due);
    resp_t r;
    r.due  = due;
    r.aerr = 1'b0;
    r.word = mmem[int'((a >> 2) % DEPTH)];
    if ((a >> (AW + 2)) != 0) r.word = NOP;
`ifdef IMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) begin
      r.word = NOP;
      r.aerr = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic model_step();
    bit empty;
    empty  = (rq.size() == 0);
    while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    m_done = 1'b0;
    case (m_phase)
      0: begin
        if (ren) rq.push_back(ref_fetch(addr, cyc + LAT));
        if (ld_start) m_phase = 1;
      end
      1: begin
        if (empty) begin
          m_phase = 2;
          m_ptr   = 0;
        end
      end
      default: begin
        if (ld_valid) begin
          mmem[m_ptr] = ld_data;
          if (ld_last || m_ptr == DEPTH - 1) begin
            m_count = m_ptr + 1;
            m_done  = 1'b1;
            m_phase = 0;
          end
          m_ptr++;
        end
      end
    endcase
    cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        rq.delete();
        m_phase = 0;
        m_count = 0;
        m_done  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      check("valid", exIns_valid, exp_v);
      if (exp_v) check("data", exIns_in, rq[0].word);
      check("busy", busy, m_phase != 0);
      check("ld_ready", ld_ready, m_phase == 2);
      check("ld_done", ld_done, m_done);
      check("ld_count", ld_count, 32'(m_count));
`ifdef IMEM_ALIGN_CHECK_EN
      check("align_err", align_err, exp_v && rq[0].aerr);
`endif
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  logic        st_ren   [16];
  logic [31:0] st_addr  [16];
  logic        st_start [16];
  logic        cap_v    [16];
  logic [31:0] cap_d    [16];
  logic        cap_rdy  [16];
  logic        cap_done [16];
  logic        cap_ae   [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_script();
    for (int i = 0; i < 16; i++) begin
      st_ren[i]   = 1'b0;
      st_addr[i]  = '0;
      st_start[i] = 1'b0;
    end
  endtask

  // Plays the script one cycle per entry and captures outputs mid-cycle.
  task automatic run_script(input int n);
    for (int i = 0; i < n; i++) begin
      ren      = st_ren[i];
      addr     = st_addr[i];
      ld_start = st_start[i];
      @(negedge clk);
      cap_v[i]    = exIns_valid;
      cap_d[i]    = exIns_in;
      cap_rdy[i]  = ld_ready;
      cap_done[i] = ld_done;
`ifdef IMEM_ALIGN_CHECK_EN
      cap_ae[i]   = align_err;
`else
      cap_ae[i]   = 1'b0;
`endif
      tick();
    end
    ren      = 1'b0;
    ld_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int waited = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(negedge clk);
    while (!ld_ready && waited < 64) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check("beat_ready_wait", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  logic [31:0] a_words [4];
  logic [31:0] b0, c0, c1;

  initial begin
    a_words = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    b0 = 32'hB000_00B0;
    c0 = 32'hC000_0C00;
    c1 = 32'hC111_1C11;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", exIns_valid, 1'b0);
    check("rst_data", exIns_in, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_done", ld_done, 1'b0);
    check("rst_count", ld_count, 32'h0);
    tick();
    nrst = 1'b1;
    tick();

    // Full-array load ended by pointer wrap (no ld_last).
    pulse_start();
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      ld_data = $urandom;
      tick();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("wrap_count", ld_count, 32'd1024);
    check("wrap_busy", busy, 1'b0);
    tick();

    // Four-word load.
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(a_words[i], i == 3);
    @(negedge clk);
    check("load4_done", ld_done, 1'b1);
    check("load4_count", ld_count, 32'd4);
    check("load4_busy", busy, 1'b0);
    tick();

    // Back-to-back fetches of words 0..3.
    clear_script();
    for (int i = 0; i < 4; i++) begin
      st_ren[i]  = 1'b1;
      st_addr[i] = 32'(i * 4);
    end
    run_script(10);
    for (int i = 0; i < 10; i++) begin
      check("b2b_valid", cap_v[i], (i >= LAT) && (i < LAT + 4));
      if (i >= LAT && i < LAT + 4) check("b2b_data", cap_d[i], a_words[i-LAT]);
    end

    // Out-of-range fetch, then an isolated fetch of word 2.
    clear_script();
    st_ren[0] = 1'b1; st_addr[0] = 32'h0010_0000;
    st_ren[2] = 1'b1; st_addr[2] = 32'h0000_0008;
    run_script(8);
    check("oor_valid", cap_v[LAT], 1'b1);
    check("oor_data", cap_d[LAT], NOP);
    check("gap_valid", cap_v[LAT+1], 1'b0);
    check("w2_valid", cap_v[LAT+2], 1'b1);
    check("w2_data", cap_d[LAT+2], a_words[2]);
    check("w2_early", cap_v[LAT+1], 1'b0);

    // ld_start with two fetches in flight; later fetches must be ignored.
    clear_script();
    st_ren[0] = 1'b1; st_addr[0] = 32'h0;
    st_ren[1] = 1'b1; st_addr[1] = 32'h4; st_start[1] = 1'b1;
    for (int i = 2; i < 12; i++) begin
      st_ren[i]  = 1'b1;
      st_addr[i] = 32'h8;
    end
    run_script(12);
    for (int i = 0; i < 12; i++) begin
      check("drain_valid", cap_v[i], (i == LAT) || (i == LAT + 1));
    end
    check("drain_d0", cap_d[LAT], a_words[0]);
    check("drain_d1", cap_d[LAT+1], a_words[1]);
    check("drain_rdy_low", cap_rdy[LAT+1], 1'b0);
    check("drain_rdy_high", cap_rdy[LAT+3], 1'b1);
    send_beat(b0, 1'b1);

    // Fetch in the ld_done cycle sees the new word.
    clear_script();
    st_ren[0] = 1'b1; st_addr[0] = 32'h0;
    run_script(LAT + 2);
    check("wr_rd_done", cap_done[0], 1'b1);
    check("wr_rd_valid", cap_v[LAT], 1'b1);
    check("wr_rd_data", cap_d[LAT], b0);

`ifdef IMEM_ALIGN_CHECK_EN
    clear_script();
    st_ren[0] = 1'b1; st_addr[0] = 32'h6;
    run_script(LAT + 2);
    check("align_valid", cap_v[LAT], 1'b1);
    check("align_data", cap_d[LAT], NOP);
    check("align_flag", cap_ae[LAT], 1'b1);
`endif

    // Random traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      ren = ($urandom_range(99) < 70);
      if ($urandom_range(9) == 0) addr = $urandom | 32'h0000_1000;
      else if ($urandom_range(3) == 0) addr = $urandom & 32'h0000_0FFF;
      else addr = $urandom & 32'h0000_0FFC;
      ld_start = ($urandom_range(99) < 3);
      ld_valid = ($urandom_range(99) < 60);
      ld_last  = ($urandom_range(99) < 15);
      ld_data  = $urandom;
      tick();
    end
    ren      = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    repeat (12) tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a load keeps the words already written.
    pulse_start();
    send_beat(c0, 1'b0);
    send_beat(c1, 1'b0);
    tick();
    nrst = 1'b0;
    #2;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", ld_ready, 1'b0);
    check("abort_valid", exIns_valid, 1'b0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    clear_script();
    st_ren[0] = 1'b1; st_addr[0] = 32'h0;
    st_ren[1] = 1'b1; st_addr[1] = 32'h4;
    run_script(LAT + 3);
    check("partial_v0", cap_v[LAT], 1'b1);
    check("partial_d0", cap_d[LAT], c0);
    check("partial_v1", cap_v[LAT+1], 1'b1);
    check("partial_d1", cap_d[LAT+1], c1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
